regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file; successor to the single-write, 2-read CPU regfile.
//   Adds N read ports, M write ports with fixed priority, and same-cycle write->read bypass.
//   Adds a per-register busy scoreboard so the pipelined core can detect RAW hazards.
//   Sits between decode (read/issue) and writeback (write/clear) in the ARM datapath.
// PARAMETERS
//   DATA_W      32  register width in bits
//   ADDR_W      4   address width; DEPTH = 2**ADDR_W registers
//   NUM_RD      3   read ports (>=1)
//   NUM_WR      2   write ports (>=1); higher index = higher priority
//   BYPASS      1   1: same-cycle write data forwarded to reads; 0: reads return old value
//   RESET_IDX   1   1: reg[i] resets to i; 0: all regs reset to 0
// PORTS
//   clk_i        in   1              clock, all state on posedge
//   rst_ni       in   1              asynchronous reset, active-low
//   rd_en_i      in   NUM_RD         read enable per port
//   rd_addr_i    in   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o    out  NUM_RD*DATA_W  registered read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy_o    out  NUM_RD         registered busy flag of the addressed register
//   wr_en_i      in   NUM_WR         write enable per port
//   wr_addr_i    in   NUM_WR*ADDR_W  write addresses
//   wr_data_i    in   NUM_WR*DATA_W  write data
//   busy_set_i   in   1              mark busy_addr_i as pending (instruction issued)
//   busy_addr_i  in   ADDR_W         destination register being issued
//   busy_o       out  DEPTH          current scoreboard, bit i = reg i pending
// BEHAVIOUR
//   Reset (rst_ni low, async): reg[i] = RESET_IDX ? i : 0; rd_data_o = 0; rd_busy_o = 0; busy_o = 0.
//   Read: latency 1. rd_en_i[k]=1 at edge N -> rd_data_o[k] valid after edge N; rd_en_i[k]=0 holds.
//   Write: wr_en_i[j]=1 at edge N -> reg updated at edge N, visible to reads issued at edge N+1.
//   Write collision (two ports, same addr, same cycle): highest-index enabled port wins.
//   BYPASS=1: read addr matches an enabled write addr same cycle -> rd_data_o = winning write data.
//   BYPASS=0: same case -> rd_data_o = pre-write register contents.
//   Scoreboard: busy_set_i sets busy[busy_addr_i]; any enabled write to reg r clears busy[r].
//   Set and clear of same reg same cycle: set wins (new producer supersedes the retiring one).
//   rd_busy_o[k]: registered with rd_data_o; reflects busy after this cycle's set/clear
//     when BYPASS=1, busy before this cycle's update when BYPASS=0.
//   Addresses wrap naturally within ADDR_W bits; no out-of-range case exists.
//   Reset asserted mid-operation: all state returns to reset values immediately; writes lost.
//   No register is hardwired; PC handling stays outside this block.
// STRUCTURE
//   Shared include regfile_pkg.vh: DEPTH derivation macro, port slice macros,
//     reset-value function (index vs zero).
//   One sub-module regfile_wr_sel: per-target-address write resolution (priority encode
//     over NUM_WR ports -> hit flag + winning data); instanced once for storage update
//     and reused for each read port's bypass compare.
//   Top level: storage array, scoreboard vector, NUM_RD read pipelines via generate.
// TESTING
//   Reset: release rst_ni, read all 16 regs on 3 ports -> rd_data_o = 0..15, busy_o = 0.
//   Write/read: wr0 reg3=0xDEADBEEF at edge N, read reg3 at N+1 -> 0xDEADBEEF after N+1.
//   Collision: wr0 reg5=0x11, wr1 reg5=0x22 same cycle -> reg5 reads 0x22.
//   Bypass: BYPASS=1, wr1 reg7=0xA5A5 and rd port2 reg7 same cycle -> rd_data_o[2]=0xA5A5;
//     BYPASS=0 build -> old value 7.
//   Scoreboard: busy_set reg4 -> busy_o[4]=1; write reg4 -> 0; set+write reg4 same cycle -> stays 1.
//   Async reset mid-write: drop rst_ni between edges -> outputs 0 at once; reg2 reads 2 after release.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the default geometry of the ARM core register file and the
// helper that picks a register's reset contents (its own index or zero).
// No ports; imported by regfile_wr_sel and regfile_mp.
package regfile_mp_pkg;

    localparam int DefDataW = 32;
    localparam int DefAddrW = 4;

    // Reset contents of register idx: the index itself makes freshly reset
    // registers distinguishable, which helps bring-up; zero is the classic choice.
    function automatic int unsigned resetValue(input int unsigned idx, input bit useIdx);
        return useIdx ? idx : 32'd0;
    endfunction

endpackage

// File: rtl/regfile_wr_sel.sv
// Write resolution for one target address.
// Scans all write ports, reports whether any enabled port targets tgt_addr_i
// and which data wins when several do (highest port index has priority).
// Ports:
//   wr_en_i    NUM_WR         write enable per port
//   wr_addr_i  NUM_WR*ADDR_W  write addresses, port j at [j*ADDR_W +: ADDR_W]
//   wr_data_i  NUM_WR*DATA_W  write data, port j at [j*DATA_W +: DATA_W]
//   tgt_addr_i ADDR_W         address being resolved
//   hit_o      1              some enabled port writes tgt_addr_i
//   data_o     DATA_W         data of the winning port (0 when no hit)
module regfile_wr_sel
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DefDataW,
    parameter int ADDR_W = DefAddrW,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]        tgt_addr_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o
);

    // Ascending scan: a later (higher-index) matching port overwrites an
    // earlier one, which gives the required fixed priority.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == tgt_addr_i)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[j*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with RAW scoreboard.
// NUM_RD registered read ports, NUM_WR prioritised write ports, optional
// same-cycle write->read bypass and a per-register busy bit.
// Ports:
//   clk_i        clock, all state on posedge
//   rst_ni       asynchronous reset, active-low
//   rd_en_i      read enable per port
//   rd_addr_i    read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o    registered read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy_o    registered busy flag of the addressed register
//   wr_en_i      write enable per port
//   wr_addr_i    write addresses
//   wr_data_i    write data
//   busy_set_i   mark busy_addr_i as pending
//   busy_addr_i  destination register being issued
//   busy_o       current scoreboard, bit i = reg i pending
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W    = DefDataW,
    parameter int ADDR_W    = DefAddrW,
    parameter int NUM_RD    = 3,
    parameter int NUM_WR    = 2,
    parameter int BYPASS    = 1,
    parameter int RESET_IDX = 1,
    localparam int DEPTH    = 2 ** ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     busy_set_i,
    input  logic [ADDR_W-1:0]        busy_addr_i,
    output logic [DEPTH-1:0]         busy_o
);

    logic [DATA_W-1:0] regs_q   [DEPTH];
    logic [DATA_W-1:0] regs_d   [DEPTH];
    logic [DATA_W-1:0] regWrData[DEPTH];
    logic [DEPTH-1:0]  regHit;
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // One resolver per register decides whether and with what it is written.
    // Busy bit: a new issue outranks a retiring write to the same register.
    for (genvar i = 0; i < DEPTH; i++) begin : gRegs
        regfile_wr_sel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) uWrSel (
            .wr_en_i    (wr_en_i),
            .wr_addr_i  (wr_addr_i),
            .wr_data_i  (wr_data_i),
            .tgt_addr_i (ADDR_W'(i)),
            .hit_o      (regHit[i]),
            .data_o     (regWrData[i])
        );

        assign regs_d[i] = regHit[i] ? regWrData[i] : regs_q[i];
        assign busy_d[i] = (busy_set_i && (busy_addr_i == ADDR_W'(i))) ||
                           (busy_q[i] && !regHit[i]);
    end

    // Storage and scoreboard; reset aborts any in-flight write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_W'(resetValue(i, RESET_IDX != 0));
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

    // Read pipelines. With bypass the port sees the value and busy state
    // this cycle will leave behind; without it, the state before the edge.
    for (genvar k = 0; k < NUM_RD; k++) begin : gRead
        logic [ADDR_W-1:0] rdAddr;
        logic              rdHit;
        logic [DATA_W-1:0] rdWrData;
        logic [DATA_W-1:0] rdData_d;
        logic              rdBusy_d;
        logic [DATA_W-1:0] rdData_q;
        logic              rdBusy_q;

        assign rdAddr = rd_addr_i[k*ADDR_W +: ADDR_W];

        regfile_wr_sel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) uBypSel (
            .wr_en_i    (wr_en_i),
            .wr_addr_i  (wr_addr_i),
            .wr_data_i  (wr_data_i),
            .tgt_addr_i (rdAddr),
            .hit_o      (rdHit),
            .data_o     (rdWrData)
        );

        assign rdData_d = ((BYPASS != 0) && rdHit) ? rdWrData : regs_q[rdAddr];
        assign rdBusy_d = (BYPASS != 0) ? busy_d[rdAddr] : busy_q[rdAddr];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rdData_q <= '0;
                rdBusy_q <= 1'b0;
            end else if (rd_en_i[k]) begin
                rdData_q <= rdData_d;
                rdBusy_q <= rdBusy_d;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = rdData_q;
        assign rd_busy_o[k]                  = rdBusy_q;
    end

endmodule
